tohost_monitor: RTL and testbench
=================================

# tohost_monitor

Memory-mapped test-completion and console device on the Core's data bus, next to the main memory. Test programs write a completion code to its TOHOST register and bytes to its CONSOLE register. The block latches a sticky pass/fail/timeout result for the simulation harness and buffers console bytes in a small FIFO with a drain handshake. It replaces PC-match result detection with an explicit, synthesizable completion protocol.

## Interface
- BASE_ADDR, 32'h0001_0000, base of 16-byte register window; bits [3:0] must be 0
- TIMEOUT_CYCLES, 5000, watchdog limit in cycles; 0 disables the watchdog
- FIFO_DEPTH, 8, console FIFO entries; power of two, at least 2
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  1  bus request present
- req_we  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_wstrb  input  4  byte write enables
- req_ready  output  1  request accepted this cycle when high with req_valid
- rsp_valid  output  1  read data valid, single-cycle pulse
- rsp_rdata  output  32  read data
- con_valid  output  1  console byte available
- con_data  output  8  console byte, head of FIFO
- con_ready  input  1  consumer takes con_data when high with con_valid
- done  output  1  sticky: test finished (pass, fail or timeout)
- passed  output  1  sticky: TOHOST written with 1
- timeout  output  1  sticky: watchdog expired
- fail_code  output  31  req_wdata[31:1] of the failing TOHOST write

## Operation
- Decode: a request hits when req_addr[31:4] == BASE_ADDR[31:4]. A non-hit request gets req_ready=1 and has no effect and no response.
- Accept: req_valid && req_ready sampled at posedge.
- req_ready is 0 only for a hit write to CONSOLE while the FIFO is full. A pop in the same cycle does not relieve this.
- Offset 0x0, TOHOST:
  - Write takes effect only with req_wstrb==4'hF, in state RUN.
  - wdata==1 -> PASS.
  - wdata odd and >1 -> FAIL, with fail_code=wdata[31:1].
  - 0 or even values are ignored.
  - Read returns the last accepted TOHOST word (reset 0).
- Offset 0x4, CONSOLE:
  - Write with req_wstrb[0]=1 pushes req_wdata[7:0]. Other strobes are ignored.
  - Read returns the FIFO count, zero-extended.
- Offset 0x8, CYCLE: read returns the cycle counter. Writes are ignored.
- Offset 0xC: reads 0, writes ignored.
- Result FSM states are RUN, PASS, FAIL, TIMEOUT. Only RUN has exits. Terminal states hold until rst.
  - done=1 in PASS, FAIL and TIMEOUT.
  - passed=1 only in PASS. timeout=1 only in TIMEOUT.
  - fail_code is nonzero only in FAIL.
  - TOHOST writes in terminal states are ignored; they do not update the stored word.
- Watchdog:
  - Counter is 32 bits, starts at 0 after reset, and increments every cycle in RUN. It freezes on leaving RUN.
  - When counter == TIMEOUT_CYCLES-1 in RUN, the FSM goes to TIMEOUT on that edge.
  - An accepted terminal TOHOST write on the same edge wins (PASS/FAIL).
- Console FIFO: circular, pointers wrap modulo FIFO_DEPTH.
  - Pop occurs on con_valid && con_ready.
  - Push and pop in the same cycle with count in 1..DEPTH-1 leave count unchanged.
  - Push into an empty FIFO appears on con_data the next cycle. There is no bypass.
  - Console writes are accepted in every FSM state.

## Timing
- Reset values:
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - con_valid=0, con_data=0.
  - done=passed=timeout=0, fail_code=0.
  - FSM=RUN, counter=0, FIFO empty.
- req_ready is combinational from req_valid, req_we, req_addr and FIFO full.
- Read latency is 1: rsp_valid=1 the cycle after acceptance, and rsp_rdata is registered. rsp_rdata holds its value until the next read.
- Back-to-back reads yield back-to-back rsp_valid pulses. Writes produce no response.
- done, passed, timeout and fail_code are registered and assert the cycle after the accepting edge.
- CYCLE read returns the counter value at the accepting edge.
- rst asserted mid-operation clears everything immediately, including FIFO contents and any pending rsp_valid.

## Test plan
- Reset, then TOHOST write 32'h1 at cycle 10 -> passed=1 and done=1 next cycle; CYCLE read returns frozen value 10; a later write of 32'h7 leaves passed=1 and fail_code=0.
- TOHOST write 32'h0000_0007 -> done=1, passed=0, fail_code=3. Write 32'h2 in RUN first -> ignored, done stays 0.
- TIMEOUT_CYCLES=20, no writes -> timeout=done=1 after the edge where counter==19. Separately, a TOHOST write of 1 on exactly that edge -> passed=1, timeout=0.
- Push 9 CONSOLE bytes 0x41..0x49 with con_ready=0 -> 8 accepted, the 9th stalls (req_ready=0). Raise con_ready -> 0x41..0x48 drain in order, then 0x49 is accepted and drained; count reads 0 at the end.
- Simultaneous push and pop at count 3 -> count stays 3 and order is preserved. TOHOST write with wstrb=4'h1 -> ignored.
- Assert rst while FIFO holds 4 bytes and done=1 -> all outputs return to reset values asynchronously; a read to 0xC and a read to a non-hit address -> 0 with rsp_valid, and no response, respectively.

Source files
------------

// File: rtl/tohost_monitor.sv
// tohost_monitor
//   Memory-mapped test-completion and console device on the data bus.
//   Register window (16 bytes at BASE_ADDR):
//     0x0 TOHOST  : write 1 = pass, odd >1 = fail (code = wdata[31:1]);
//                   read returns the last accepted TOHOST word
//     0x4 CONSOLE : write pushes wdata[7:0] (wstrb[0]); read returns FIFO count
//     0x8 CYCLE   : read-only cycle counter (frozen once the result is latched)
//     0xC         : reads 0, writes ignored
//   Ports:
//     clk, rst                      clock, async active-high reset
//     req_valid/we/addr/wdata/wstrb bus request, req_ready accept
//     rsp_valid, rsp_rdata          one-cycle read response
//     con_valid, con_data, con_ready console byte drain handshake
//     done, passed, timeout, fail_code  sticky test result
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; valid never waits for ready, and ready may depend on valid.
module tohost_monitor #(
   parameter logic [31:0] BASE_ADDR      = 32'h0001_0000,
   parameter int unsigned TIMEOUT_CYCLES = 5000,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        con_valid,
   output logic [7:0]  con_data,
   input  logic        con_ready,
   output logic        done,
   output logic        passed,
   output logic        timeout,
   output logic [30:0] fail_code
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_PASS    = 2'd1;
   localparam logic [1:0] ST_FAIL    = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   logic [1:0]       state;
   logic [31:0]      cycle_cnt;
   logic [31:0]      tohost_word;
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;

   logic        hit;
   logic [1:0]  offset;
   logic        fifo_full;
   logic        accept;
   logic        rd_acc;
   logic        push;
   logic        pop;
   logic        tohost_wr;
   logic        wd_expire;
   logic [31:0] rd_mux;
   logic        unused_addr_bits;

   assign hit       = (req_addr[31:4] == BASE_ADDR[31:4]);
   assign offset    = req_addr[3:2];
   assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign unused_addr_bits = ^req_addr[1:0];

   // Only a console push into a full FIFO is back-pressured. A pop in the
   // same cycle deliberately does not open the slot, keeping ready free of
   // any dependency on con_ready.
   assign req_ready = !(req_valid && req_we && hit && (offset == 2'd1) && fifo_full);
   assign accept    = req_valid && req_ready;
   assign rd_acc    = accept && !req_we && hit;
   assign push      = accept && req_we && hit && (offset == 2'd1) && req_wstrb[0];
   assign pop       = con_valid && con_ready;
   assign tohost_wr = accept && req_we && hit && (offset == 2'd0) &&
                      (req_wstrb == 4'hF) && (state == ST_RUN);

   // A limit of zero disables the watchdog entirely.
   assign wd_expire = (TIMEOUT_CYCLES != 0) &&
                      (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_comb begin
      rd_mux = 32'h0;
      case (offset)
         2'd0:    rd_mux = tohost_word;
         2'd1:    rd_mux = 32'(fifo_count);
         2'd2:    rd_mux = cycle_cnt;
         default: rd_mux = 32'h0;
      endcase
   end

   // Result FSM and watchdog. A terminal TOHOST write on the expiry edge
   // takes priority over the timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         cycle_cnt   <= 32'h0;
         tohost_word <= 32'h0;
         fail_code   <= 31'h0;
      end else if (state == ST_RUN) begin
         cycle_cnt <= cycle_cnt + 32'h1;
         if (tohost_wr)
            tohost_word <= req_wdata;
         if (tohost_wr && (req_wdata == 32'h1)) begin
            state <= ST_PASS;
         end else if (tohost_wr && req_wdata[0]) begin
            state     <= ST_FAIL;
            fail_code <= req_wdata[31:1];
         end else if (wd_expire) begin
            state <= ST_TIMEOUT;
         end
      end
   end

   assign done    = (state != ST_RUN);
   assign passed  = (state == ST_PASS);
   assign timeout = (state == ST_TIMEOUT);

   // Read response: rsp_rdata keeps its value until the next accepted read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0;
      end else begin
         rsp_valid <= rd_acc;
         if (rd_acc)
            rsp_rdata <= rd_mux;
      end
   end

   // Console FIFO storage; emptiness is tracked by fifo_count, so the data
   // array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= req_wdata[7:0];
   end

   // Pointers wrap naturally because the depth is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   assign con_valid = (fifo_count != '0);
   assign con_data  = con_valid ? fifo_mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor
//   Directed bench for tohost_monitor (watchdog limit 20 cycles).
//   Register-level behaviour is a table of single-cycle bus operations with
//   hand-computed results; FIFO, watchdog and reset corners are written out.
module tb_tohost_monitor;

   localparam logic [31:0] BASE   = 32'h0001_0000;
   localparam logic [31:0] A_TOH  = BASE + 32'h0;
   localparam logic [31:0] A_CON  = BASE + 32'h4;
   localparam logic [31:0] A_CYC  = BASE + 32'h8;
   localparam logic [31:0] A_RSV  = BASE + 32'hC;
   localparam logic [31:0] A_MISS = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_ready, rsp_valid;
   logic [31:0] rsp_rdata;
   logic        con_valid;
   logic [7:0]  con_data;
   logic        con_ready;
   logic        done, passed, timeout;
   logic [30:0] fail_code;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   tohost_monitor #(
      .BASE_ADDR      (BASE),
      .TIMEOUT_CYCLES (20),
      .FIFO_DEPTH     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .con_valid (con_valid),
      .con_data  (con_data),
      .con_ready (con_ready),
      .done      (done),
      .passed    (passed),
      .timeout   (timeout),
      .fail_code (fail_code)
   );

   // clock / reset
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_rsp_valid;
      logic [31:0] exp_rdata;
      logic        exp_done;
      logic [30:0] exp_fail;
   } vec_t;

   vec_t tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic bus_idle();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_wstrb = 4'h0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Holds reset over two edges and releases it 1 time unit after an edge.
   task automatic do_reset();
      bus_idle();
      con_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr;
      req_wdata = data;
      req_wstrb = strb;
      cyc();
      bus_idle();
   endtask

   task automatic bus_read(input string name, input logic [31:0] addr,
                           input logic exp_v, input logic [31:0] exp_d);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr;
      cyc();
      bus_idle();
      check({name, "_rsp_valid"}, rsp_valid, exp_v);
      if (exp_v)
         check({name, "_rdata"}, rsp_rdata, exp_d);
   endtask

   task automatic push_byte(input logic [7:0] b);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = A_CON;
      req_wdata = {24'hABCDEF, b};
      req_wstrb = 4'h1;
      #1;
      check("push_ready", req_ready, 1'b1);
      cyc();
      bus_idle();
      exp_q.push_back(b);
   endtask

   task automatic check_result(input string name, input logic d, input logic p,
                               input logic t, input logic [30:0] f);
      check({name, "_done"}, done, d);
      check({name, "_passed"}, passed, p);
      check({name, "_timeout"}, timeout, t);
      check({name, "_fail_code"}, 32'(fail_code), 32'(f));
   endtask

   initial begin
      int drained;
      bit accepted9;

      // Rows are consecutive edges from reset release; row i is accepted
      // while the cycle counter equals i (as long as the FSM is in RUN).
      tbl[0]  = '{1'b1, A_TOH,            32'h2,    4'hF, 1'b0, 32'h0, 1'b0, 31'd0};
      tbl[1]  = '{1'b0, A_TOH,            32'h0,    4'h0, 1'b1, 32'h2, 1'b0, 31'd0};
      tbl[2]  = '{1'b0, A_MISS,           32'h0,    4'h0, 1'b0, 32'h2, 1'b0, 31'd0};
      tbl[3]  = '{1'b1, 32'h0001_0010,    32'h1,    4'hF, 1'b0, 32'h2, 1'b0, 31'd0};
      tbl[4]  = '{1'b0, A_CYC,            32'h0,    4'h0, 1'b1, 32'h4, 1'b0, 31'd0};
      tbl[5]  = '{1'b1, A_TOH,            32'h7,    4'h1, 1'b0, 32'h4, 1'b0, 31'd0};
      tbl[6]  = '{1'b0, A_TOH,            32'h0,    4'h0, 1'b1, 32'h2, 1'b0, 31'd0};
      tbl[7]  = '{1'b1, A_TOH,            32'h7,    4'hF, 1'b0, 32'h2, 1'b1, 31'd3};
      tbl[8]  = '{1'b0, A_TOH,            32'h0,    4'h0, 1'b1, 32'h7, 1'b1, 31'd3};
      tbl[9]  = '{1'b1, A_TOH,            32'h1,    4'hF, 1'b0, 32'h7, 1'b1, 31'd3};
      tbl[10] = '{1'b0, A_TOH,            32'h0,    4'h0, 1'b1, 32'h7, 1'b1, 31'd3};
      tbl[11] = '{1'b0, A_CYC,            32'h0,    4'h0, 1'b1, 32'h8, 1'b1, 31'd3};
      tbl[12] = '{1'b0, A_RSV,            32'h0,    4'h0, 1'b1, 32'h0, 1'b1, 31'd3};
      tbl[13] = '{1'b1, A_CYC,            32'hFFFF, 4'hF, 1'b0, 32'h0, 1'b1, 31'd3};
      tbl[14] = '{1'b0, A_CYC,            32'h0,    4'h0, 1'b1, 32'h8, 1'b1, 31'd3};
      tbl[15] = '{1'b0, A_CON,            32'h0,    4'h0, 1'b1, 32'h0, 1'b1, 31'd3};

      bus_idle();
      con_ready = 1'b0;
      rst = 1'b1;
      #3;
      // reset values
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_con_valid", con_valid, 1'b0);
      check("rst_con_data", con_data, 8'h00);
      check_result("rst", 1'b0, 1'b0, 1'b0, 31'd0);

      // register table (ends in FAIL with code 3)
      do_reset();
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1;
         req_we    = tbl[i].we;
         req_addr  = tbl[i].addr;
         req_wdata = tbl[i].wdata;
         req_wstrb = tbl[i].wstrb;
         #1;
         check($sformatf("tbl%0d_ready", i), req_ready, 1'b1);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_rsp_valid", i), rsp_valid, tbl[i].exp_rsp_valid);
         check($sformatf("tbl%0d_rdata", i), rsp_rdata, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
         check($sformatf("tbl%0d_passed", i), passed, 1'b0);
         check($sformatf("tbl%0d_fail", i), 32'(fail_code), 32'(tbl[i].exp_fail));
      end
      bus_idle();

      // PASS at cycle 10, frozen counter, later writes ignored
      do_reset();
      repeat (9) cyc();
      bus_write(A_TOH, 32'h1, 4'hF);
      check_result("pass", 1'b1, 1'b1, 1'b0, 31'd0);
      bus_read("pass_cycle", A_CYC, 1'b1, 32'd10);
      bus_write(A_TOH, 32'h7, 4'hF);
      check_result("pass_then_fail", 1'b1, 1'b1, 1'b0, 31'd0);
      bus_read("pass_tohost", A_TOH, 1'b1, 32'h1);
      repeat (15) cyc();
      check_result("pass_no_wd", 1'b1, 1'b1, 1'b0, 31'd0);

      // watchdog expiry on the edge where counter == 19
      do_reset();
      repeat (19) cyc();
      check_result("wd_before", 1'b0, 1'b0, 1'b0, 31'd0);
      cyc();
      check_result("wd_after", 1'b1, 1'b0, 1'b1, 31'd0);
      bus_read("wd_cycle", A_CYC, 1'b1, 32'd20);

      // TOHOST pass on the expiry edge wins
      do_reset();
      repeat (19) cyc();
      bus_write(A_TOH, 32'h1, 4'hF);
      check_result("wd_race", 1'b1, 1'b1, 1'b0, 31'd0);

      // FIFO fill, stall, drain
      do_reset();
      push_byte(8'h41);
      check("empty_push_valid", con_valid, 1'b1);
      check("empty_push_data", con_data, 8'h41);
      for (int b = 8'h42; b <= 8'h48; b++)
         push_byte(8'(b));
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = A_CON;
      req_wdata = 32'h49;
      req_wstrb = 4'h1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("full_stall_ready", req_ready, 1'b0);
         cyc();
      end
      con_ready = 1'b1;
      #1;
      check("full_pop_no_relief", req_ready, 1'b0);
      drained = 0;
      accepted9 = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (accepted9 && !con_valid && exp_q.size() == 0)
            break;
         #1;
         if (req_valid && req_ready)
            accepted9 = 1'b1;
         if (con_valid) begin
            if (exp_q.size() == 0)
               check("drain_extra", 32'(con_data), 32'hFFFF_FFFF);
            else
               check("drain_order", con_data, exp_q.pop_front());
            drained++;
         end
         cyc();
         if (accepted9 && req_valid) begin
            exp_q.push_back(8'h49);
            bus_idle();
         end
      end
      check("drain_count", drained, 9);
      check("drain_9th_accepted", accepted9, 1'b1);
      con_ready = 1'b0;
      bus_read("drain_fifo_count", A_CON, 1'b1, 32'd0);

      // simultaneous push/pop at count 3
      do_reset();
      push_byte(8'h10);
      push_byte(8'h11);
      push_byte(8'h12);
      bus_read("cnt3", A_CON, 1'b1, 32'd3);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = A_CON;
      req_wdata = 32'h13;
      req_wstrb = 4'h1;
      con_ready = 1'b1;
      #1;
      check("pp_ready", req_ready, 1'b1);
      check("pp_head", con_data, exp_q.pop_front());
      cyc();
      exp_q.push_back(8'h13);
      bus_idle();
      con_ready = 1'b0;
      bus_read("pp_count", A_CON, 1'b1, 32'd3);
      con_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("pp_valid", con_valid, 1'b1);
         check("pp_order", con_data, exp_q.pop_front());
         cyc();
      end
      check("pp_empty", con_valid, 1'b0);
      con_ready = 1'b0;

      // async reset mid-operation
      do_reset();
      bus_write(A_TOH, 32'h7, 4'hF);
      for (int b = 1; b <= 4; b++)
         push_byte(8'(b));
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = A_TOH;
      cyc();
      bus_idle();
      check("pre_rst_rsp_valid", rsp_valid, 1'b1);
      check("pre_rst_done", done, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_req_ready", req_ready, 1'b1);
      check("async_rsp_valid", rsp_valid, 1'b0);
      check("async_rsp_rdata", rsp_rdata, 32'h0);
      check("async_con_valid", con_valid, 1'b0);
      check("async_con_data", con_data, 8'h00);
      check_result("async", 1'b0, 1'b0, 1'b0, 31'd0);
      cyc();
      rst = 1'b0;
      exp_q.delete();
      bus_read("post_rst_rsv", A_RSV, 1'b1, 32'h0);
      bus_read("post_rst_miss", A_MISS, 1'b0, 32'h0);
      bus_read("post_rst_count", A_CON, 1'b1, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
